// File: rtl/fp_accum_ctrl.sv
// Accumulation sequencer around a combinational FP32 add/sub unit: loads the first
// operand, folds each further operand through the unit, and hands the result downstream.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start; acc holds the last result
// S_LOAD  | accepting the first operand straight into acc
// S_ACCUM | accepting further operands through the arithmetic unit
// S_DONE  | presenting acc downstream until out_ready
module fp_accum_ctrl #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] ACCUM_INIT = '0,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  len,
    input  logic                  op_sel,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0] arith_data_1,
    output logic [DATA_WIDTH-1:0] arith_data_2,
    output logic                  arith_op_sel,
    output logic                  arith_en,
    input  logic [DATA_WIDTH-1:0] arith_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_ACCUM = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] acc, acc_nxt;
    logic [CNT_WIDTH-1:0]  remaining, remaining_nxt;
    logic                  op_sel_q, op_sel_nxt;
    logic                  accept;
    logic                  last_operand;

    assign in_ready     = (state == S_LOAD) || (state == S_ACCUM);
    assign accept       = in_ready && in_valid;
    assign last_operand = (remaining == CNT_WIDTH'(1));

    assign arith_data_1 = acc;
    assign arith_data_2 = in_data;
    assign arith_op_sel = op_sel_q;
    assign arith_en     = (state == S_ACCUM) && in_valid;
    assign out_valid    = (state == S_DONE);
    assign out_data     = acc;
    assign busy         = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            acc       <= ACCUM_INIT;
            remaining <= '0;
            op_sel_q  <= 1'b0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            remaining <= remaining_nxt;
            op_sel_q  <= op_sel_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        acc_nxt       = acc;
        remaining_nxt = remaining;
        op_sel_nxt    = op_sel_q;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        op_sel_nxt    = op_sel;
                        remaining_nxt = len;
                        state_nxt     = S_LOAD;
                    end else begin
                        acc_nxt   = ACCUM_INIT;
                        state_nxt = S_DONE;
                    end
                end
            end
            S_LOAD: begin
                if (accept) begin
                    acc_nxt       = in_data;
                    remaining_nxt = remaining - 1'b1;
                    state_nxt     = last_operand ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (accept) begin
                    acc_nxt       = arith_result;
                    remaining_nxt = remaining - 1'b1;
                    if (last_operand) state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        // Abort wins over every other event in the same cycle.
        if (flush) begin
            state_nxt     = S_IDLE;
            acc_nxt       = ACCUM_INIT;
            remaining_nxt = '0;
        end
    end

endmodule

// File: tb/tb_fp_accum_ctrl.sv
// Randomized bench for fp_accum_ctrl using an integer add/sub stub as the arithmetic
// unit and a per-batch operand-fold model of the expected accumulator.
module tb_fp_accum_ctrl;
    localparam int          DW   = 32;
    localparam int          CW   = 4;
    localparam logic [31:0] INIT = 32'h0BAD_F00D;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] len;
    logic          op_sel;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [DW-1:0] arith_data_1;
    logic [DW-1:0] arith_data_2;
    logic          arith_op_sel;
    logic          arith_en;
    logic [DW-1:0] arith_result;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          busy;

    int            checks = 0;
    int            errors = 0;
    logic [31:0]   m_acc;
    logic          m_op;

    fp_accum_ctrl #(.DATA_WIDTH(DW), .ACCUM_INIT(INIT), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .op_sel(op_sel), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .arith_data_1(arith_data_1), .arith_data_2(arith_data_2),
        .arith_op_sel(arith_op_sel), .arith_en(arith_en), .arith_result(arith_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // Integer stand-in for the FP unit keeps the expected fold exact.
    assign arith_result = arith_op_sel ? (arith_data_1 - arith_data_2) : (arith_data_1 + arith_data_2);

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_busy"}, 32'(busy), 32'd0);
        check_val({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check_val({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check_val({tag, "_arith_en"}, 32'(arith_en), 32'd0);
        check_val({tag, "_out_data"}, out_data, m_acc);
        check_val({tag, "_data_1"}, arith_data_1, m_acc);
        check_val({tag, "_op_sel"}, 32'(arith_op_sel), 32'(m_op));
    endtask

    task automatic run_batch(input int n, input bit op, input int vpct, input int flush_at);
        int taken = 0;
        int cyc   = 0;
        bit fin   = 0;
        bit coll;
        @(posedge clk); #1;
        start = 1'b1; len = CW'(n); op_sel = op; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'($urandom); in_data = $urandom;
        @(negedge clk);
        check_idle("start_cyc");
        check_val("start_data_2", arith_data_2, in_data);
        if (n == 0) m_acc = INIT;
        else m_op = op;
        while (!fin && cyc < 200) begin
            @(posedge clk); #1;
            coll      = (taken < n);
            start     = 1'($urandom);
            len       = CW'($urandom);
            op_sel    = 1'($urandom);
            in_valid  = ($urandom_range(0, 99) < vpct);
            in_data   = $urandom;
            out_ready = !coll && ($urandom_range(0, 3) == 0);
            flush     = (flush_at >= 0) && (taken == flush_at);
            @(negedge clk);
            check_val("busy", 32'(busy), 32'd1);
            check_val("in_ready", 32'(in_ready), 32'(coll));
            check_val("out_valid", 32'(out_valid), 32'(!coll));
            check_val("arith_en", 32'(arith_en), 32'(coll && taken > 0 && in_valid));
            check_val("arith_data_1", arith_data_1, m_acc);
            check_val("arith_data_2", arith_data_2, in_data);
            check_val("arith_op_sel", 32'(arith_op_sel), 32'(m_op));
            if (!coll) check_val("out_data", out_data, m_acc);
            if (flush) begin
                m_acc = INIT;
                fin   = 1;
            end else if (coll && in_valid) begin
                if (taken == 0) m_acc = in_data;
                else if (op) m_acc = m_acc - in_data;
                else m_acc = m_acc + in_data;
                taken++;
            end else if (!coll && out_ready) begin
                fin = 1;
            end
            cyc++;
        end
        check_val("batch_completed", 32'(fin), 32'd1);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        check_idle("after_batch");
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; op_sel = 1'b0; flush = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        m_acc = INIT; m_op = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;

        run_batch(2, 1'b0, 100, -1);
        run_batch(4, 1'b1, 50, -1);
        run_batch(0, 1'b0, 100, -1);
        run_batch(5, 1'b0, 100, 2);
        run_batch(5, 1'b1, 100, -1);
        run_batch(15, 1'b0, 100, -1);
        run_batch(15, 1'b1, 40, -1);
        run_batch(1, 1'b1, 100, -1);
        run_batch(3, 1'b0, 100, 3);
        for (int i = 0; i < 30; i++) begin
            int n;
            n = $urandom_range(0, 15);
            run_batch(n, 1'($urandom), $urandom_range(30, 100),
                      ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, n)) : -1);
        end

        // Asynchronous reset while accumulating.
        @(posedge clk); #1;
        start = 1'b1; len = CW'(6); op_sel = 1'b0; in_valid = 1'b1; in_data = $urandom;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        check_val("pre_rst_arith_en", 32'(arith_en), 32'd1);
        rst = 1'b1;
        m_acc = INIT; m_op = 1'b0;
        #1;
        check_idle("async_rst");
        #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check_idle("post_rst");
        run_batch(3, 1'b1, 100, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
